// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot result encoding ordered {less_than, equal_to, greater_than}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_GT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/cmp_bit_slice.sv
// Single-bit compare slice; all outputs are forced low while the slice is
// not enabled so a gated-off slice never contributes a result.
module cmp_bit_slice (
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic lt,
    output logic eq,
    output logic gt
);

    assign lt = en & ~a_bit &  b_bit;
    assign eq = en & ~(a_bit ^ b_bit);
    assign gt = en &  a_bit & ~b_bit;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial unsigned comparator with a one-hot slice enable and a
// valid/ready result port. Define SERIAL_CMP_EARLY_EXIT_EN to stop at the
// first differing bit; otherwise every compare takes exactly WIDTH cycles.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] slice_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less_than,
    output logic             equal_to,
    output logic             greater_than,
    output state_t           state_dbg
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid/result stay frozen until out_ready is seen.
    state_t            state, state_n;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        res_q, res_n;
    logic              out_valid_q;
    logic              decided, decided_n;
    logic [2:0]        dec_res, dec_res_n;
    logic              scan_en, s_lt, s_eq, s_gt;
    logic [2:0]        bit_res;
    logic              resolved, last_bit;

    assign scan_en  = (state == SCAN);
    assign last_bit = (idx == '0);
    assign bit_res  = {s_lt, s_eq, s_gt};

    cmp_bit_slice u_slice (
        .en    (scan_en),
        .a_bit (a_q[idx]),
        .b_bit (b_q[idx]),
        .lt    (s_lt),
        .eq    (s_eq),
        .gt    (s_gt)
    );

    always_comb begin
        state_n   = state;
        res_n     = CMP_NONE;
        resolved  = 1'b0;
        decided_n = decided;
        dec_res_n = dec_res;
        case (state)
            IDLE: if (in_valid) state_n = SCAN;
            SCAN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!s_eq || last_bit) begin
                    resolved = 1'b1;
                    res_n    = bit_res;
                end
`else
                // The first mismatch is sticky; later bits only keep the clock count.
                if (!decided && !s_eq) begin
                    decided_n = 1'b1;
                    dec_res_n = bit_res;
                end
                if (last_bit) begin
                    resolved = 1'b1;
                    res_n    = decided_n ? dec_res_n : bit_res;
                end
`endif
                if (resolved) state_n = DONE;
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            res_q       <= CMP_NONE;
            out_valid_q <= 1'b0;
            decided     <= 1'b0;
            dec_res     <= CMP_NONE;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    idx     <= IDX_W'(WIDTH - 1);
                    decided <= 1'b0;
                    dec_res <= CMP_NONE;
                end
                SCAN: begin
                    decided <= decided_n;
                    dec_res <= dec_res_n;
                    if (resolved) begin
                        res_q       <= res_n;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    res_q       <= CMP_NONE;
                    out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign busy      = (state == SCAN) || (state == DONE);
    assign slice_en  = scan_en ? (WIDTH'(1) << idx) : '0;
    assign out_valid = out_valid_q;
    assign {less_than, equal_to, greater_than} = res_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: directed corner cases plus random operand pairs
// against an arithmetic reference model and an expected-result queue.
module tb_serial_magnitude_comparator;
    import cmp_pkg::*;

    localparam int W = 8;

    logic         clk, reset;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b, slice_en;
    logic         busy, out_valid, out_ready;
    logic         less_than, equal_to, greater_than;
    state_t       state_dbg;

    logic [2:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .slice_en     (slice_en),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .less_than    (less_than),
        .equal_to     (equal_to),
        .greater_than (greater_than),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return W - i;
`endif
        return W;
    endfunction

    function automatic logic [2:0] res_now();
        return {less_than, equal_to, greater_than};
    endfunction

    // One full transaction: accept, scan, hold the result for 'hold' cycles, drain.
    task automatic drive_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold);
        logic [W-1:0] top;
        logic [2:0]   exp_res, held;
        int           lat, exp_lat;
        top = {1'b1, {(W-1){1'b0}}};
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1'b1);
        a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model_result(ta, tb));
        exp_lat = model_latency(ta, tb);
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            check("slice_en_scan", slice_en, top >> lat);
            if (res_now() != 3'b000) check("result_while_scan", res_now(), 3'b000);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("out_valid_rise", out_valid, 1'b1);
        exp_res = exp_q.pop_front();
        check("result", res_now(), exp_res);
        check("onehot", $countones(res_now()), 1);
        check("slice_en_done", slice_en, '0);
        check("in_ready_done", in_ready, 1'b0);
        check("busy_done", busy, 1'b1);
        held = res_now();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("hold_result", res_now(), held);
            check("hold_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", out_valid, 1'b0);
        check("drain_result", res_now(), 3'b000);
        check("drain_in_ready", in_ready, 1'b1);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", res_now(), 3'b000);
        check("rst_slice_en", slice_en, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, IDLE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // directed cases
        drive_txn(8'hA5, 8'hA5, 0);
        drive_txn(8'h80, 8'h7F, 0);
        drive_txn(8'h12, 8'h13, 0);
        drive_txn(8'h13, 8'h12, 1);
        drive_txn(8'h01, 8'h02, 5);
        drive_txn(8'h00, 8'hFF, 0);
        drive_txn(8'hFF, 8'h00, 0);

        // reset three cycles into a scan
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_result", res_now(), 3'b000);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_slice_en", slice_en, '0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (W + 2) begin
            @(posedge clk); #1;
            check("midrst_no_stale_valid", out_valid, 1'b0);
        end

        // random pairs, biased toward equal and near-equal operands
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            drive_txn(ra, rb, $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
